// File: rtl/uart_line_buffer_pkg.sv
// uart_line_buffer_pkg: register map, bit positions, FSM states and default terminator shared by the line buffer
package uart_line_buffer_pkg;
    localparam logic [1:0] ULB_STATUS = 2'd0;
    localparam logic [1:0] ULB_DATA   = 2'd1;
    localparam logic [1:0] ULB_CTRL   = 2'd2;
    localparam int ST_AVAIL     = 0;
    localparam int ST_OVF       = 1;
    localparam int ST_ECHO_DROP = 2;
    localparam int ST_LC_LSB    = 8;
    localparam int CTRL_CLR     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam logic [7:0] ULB_TERM_CHAR = 8'd13;
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;
endpackage

// File: rtl/ulb_ram.sv
// ulb_ram: 2^ADDR_W x 8 line storage, synchronous write port and asynchronous read port
module ulb_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);
    logic [7:0] r_mem [2**ADDR_W];
    // store each accepted receive byte
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_line_buffer.sv
// uart_line_buffer: commits UART bytes to the CPU a whole line at a time; optional echo via UART_LINE_BUFFER_ECHO_EN
module uart_line_buffer
    import uart_line_buffer_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] TERM_CHAR = ULB_TERM_CHAR,
    parameter int         DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [1:0]          address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;

    state_t            r_state, w_next_state;
    logic [PW-1:0]     r_wr_ptr, r_line_start, r_rd_ptr, r_line_count;
    logic              r_overflow, r_ready;
    logic [DATA_W-1:0] r_rdata, w_status, w_rd_val;
    logic [7:0]        w_ram_q;
    logic              w_full, w_is_term, w_accept, w_write_req, w_flush, w_clr;
    logic              w_avail, w_pop, w_pop_term, w_rx, w_we, w_ovf, w_commit;
    logic              w_echo_drop, w_unused;

    ulb_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (rx_data),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_ram_q)
    );

    assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH;
    assign w_is_term   = rx_data == TERM_CHAR;
    assign w_accept    = valid && !r_ready;
    assign w_write_req = |wstrb;
    assign w_flush     = w_accept && w_write_req && address == ULB_CTRL && wdata[CTRL_FLUSH];
    assign w_clr       = w_accept && w_write_req && address == ULB_CTRL && wdata[CTRL_CLR];
    assign w_avail     = r_rd_ptr != r_line_start;
    assign w_pop       = w_accept && !w_write_req && address == ULB_DATA && w_avail;
    assign w_pop_term  = w_pop && w_ram_q == TERM_CHAR;
    assign w_rx        = rx_valid && !w_flush;
    assign w_ovf       = w_rx && w_full;
    assign w_we        = w_rx && !w_full && r_state != DISCARD;
    assign w_commit    = w_we && w_is_term;

    // next line-assembly state: a terminator always ends the line, overflow drops the rest of it
    always_comb begin
        w_next_state = r_state;
        if (w_flush)
            w_next_state = IDLE;
        else if (w_rx)
            w_next_state = w_is_term ? IDLE : (w_ovf || r_state == DISCARD) ? DISCARD : COLLECT;
    end

    // read mux: STATUS fields and DATA pop value; writes and unmapped addresses read 0
    always_comb begin
        w_status = '0;
        w_status[ST_AVAIL] = w_avail;
        w_status[ST_OVF] = r_overflow;
        w_status[ST_ECHO_DROP] = w_echo_drop;
        w_status[ST_LC_LSB +: PW] = r_line_count;
        w_rd_val = w_write_req ? '0 :
                   address == ULB_STATUS ? w_status :
                   address == ULB_DATA && w_avail ? {{(DATA_W-9){1'b0}}, 1'b1, w_ram_q} : '0;
    end

    // FSM state, FIFO pointers, line counter and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_line_start <= '0;
            r_rd_ptr     <= '0;
            r_line_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_flush) begin
                r_wr_ptr     <= '0;
                r_line_start <= '0;
                r_rd_ptr     <= '0;
                r_line_count <= '0;
            end else begin
                if (w_ovf)
                    r_wr_ptr <= r_line_start;
                else if (w_we)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_commit)
                    r_line_start <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_line_count <= r_line_count + PW'(w_commit) - PW'(w_pop_term);
            end
            r_overflow <= w_ovf ? 1'b1 : w_clr ? 1'b0 : r_overflow;
        end
    end

    // one-cycle bus acknowledge with registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_accept ? w_rd_val : '0;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;

`ifdef UART_LINE_BUFFER_ECHO_EN
    logic       r_tx_valid, r_echo_drop;
    logic [7:0] r_tx_data;
    // single-entry echo holding register; a byte arriving while it is busy loses its echo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_echo_drop <= 1'b0;
        end else begin
            if (w_we && !(r_tx_valid && !tx_ready)) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= rx_data;
            end else if (r_tx_valid && tx_ready)
                r_tx_valid <= 1'b0;
            r_echo_drop <= (w_we && r_tx_valid && !tx_ready) ? 1'b1 : w_clr ? 1'b0 : r_echo_drop;
        end
    end
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign w_echo_drop = r_echo_drop;
    assign w_unused    = ^wdata[DATA_W-1:2];
`else
    assign tx_valid    = 1'b0;
    assign tx_data     = '0;
    assign w_echo_drop = 1'b0;
    assign w_unused    = ^{tx_ready, wdata[DATA_W-1:2]};
`endif
endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer: scenario tasks plus randomized traffic checked against a queue-based line model
module tb_uart_line_buffer;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam logic [1:0] A_ST = 2'd0, A_DT = 2'd1, A_CT = 2'd2;

    logic        clk = 0, reset = 1, valid = 0, rx_valid = 0, tx_ready = 0;
    logic [1:0]  address = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic [7:0]  rx_data = 0, tx_data;
    logic        ready, tx_valid;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_line_buffer #(.ADDR_W(AW), .TERM_CHAR(8'd13), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    logic [7:0] m_com[$], m_pend[$];
    bit m_disc, m_ovf, m_tx_occ, m_edrop;
    logic [7:0] m_tx_data;

    function automatic logic [31:0] m_status();
        int lc = 0;
        foreach (m_com[i]) if (m_com[i] == 8'd13) lc++;
        return (32'(lc) << 8) | (32'(m_edrop) << 2) | (32'(m_ovf) << 1) | 32'(m_com.size() != 0);
    endfunction

    function automatic logic [31:0] m_pop();
        logic [7:0] b;
        if (m_com.size() == 0) return 32'h0;
        b = m_com.pop_front();
        return {23'h0, 1'b1, b};
    endfunction

    function automatic void m_rx(input logic [7:0] b, input int extra);
        if (m_com.size() + m_pend.size() + extra == DEPTH) begin
            m_pend.delete();
            m_ovf = 1;
            m_disc = (b != 8'd13);
        end else if (m_disc) begin
            if (b == 8'd13) m_disc = 0;
        end else begin
            m_pend.push_back(b);
`ifdef UART_LINE_BUFFER_ECHO_EN
            if (m_tx_occ) m_edrop = 1;
            else begin
                m_tx_occ = 1;
                m_tx_data = b;
            end
`endif
            if (b == 8'd13) begin
                foreach (m_pend[i]) m_com.push_back(m_pend[i]);
                m_pend.delete();
            end
        end
    endfunction

    function automatic void m_reset();
        m_com.delete(); m_pend.delete();
        m_disc = 0; m_ovf = 0; m_tx_occ = 0; m_edrop = 0; m_tx_data = 0;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        m_reset();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_valid = 1;
        @(posedge clk); #1 rx_valid = 0;
        m_rx(b, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
        int n = 0;
        @(posedge clk); #1 valid = 1; address = a; wdata = d; wstrb = s;
        do begin
            @(posedge clk); #1 n++;
        end while (!ready && n < 8);
        if (!ready) begin
            bad++;
            $display("FAIL bus_timeout ready=%b required=1", ready);
        end
        r = rdata;
        valid = 0; wstrb = 0; wdata = 0;
    endtask

    task automatic do_simul(input logic [7:0] b, output logic [31:0] r, output logic [31:0] e);
        @(posedge clk); #1 valid = 1; address = A_DT; wstrb = 0; rx_data = b; rx_valid = 1;
        @(posedge clk); #1 rx_valid = 0; valid = 0;
        if (!ready) begin
            bad++;
            $display("FAIL simul_ready ready=%b required=1", ready);
        end
        r = rdata;
        e = m_pop();
        m_rx(b, 32'(e[8]));
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        total++; if (ready !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL reset_bus ready=%b rdata=%h required 0/0", ready, rdata); end
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin bad++; $display("FAIL reset_tx tx_valid=%b tx_data=%h required 0/0", tx_valid, tx_data); end
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", r); end
    endtask

    task automatic test_basic_line();
        logic [31:0] r, e;
        send("A"); send("B"); send(8'd13);
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h101 || r !== m_status()) begin bad++; $display("FAIL basic_status got=%h exp=%h", r, 32'h101); end
        for (int i = 0; i < 3; i++) begin
            bus(A_DT, 0, 0, r); e = m_pop();
            total++; if (r !== e) begin bad++; $display("FAIL basic_pop%0d got=%h exp=%h", i, r, e); end
        end
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL basic_status_empty got=%h exp=0", r); end
    endtask

    task automatic test_uncommitted();
        logic [31:0] r, e;
        send("A"); send("B");
        bus(A_ST, 0, 0, r);
        total++; if (r[0] !== 1'b0 || r !== m_status()) begin bad++; $display("FAIL uncommitted_status got=%h exp=%h", r, m_status()); end
        bus(A_DT, 0, 0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL uncommitted_data got=%h exp=0", r); end
        send(8'd13);
        for (int i = 0; i < 3; i++) begin
            bus(A_DT, 0, 0, r); e = m_pop();
            total++; if (r !== e) begin bad++; $display("FAIL uncommitted_drain%0d got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r, e;
        logic [7:0] s [6];
        s = '{"W", "X", "Y", "Z", "Q", 8'd13};
        foreach (s[i]) send(s[i]);
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h2 || r !== m_status()) begin bad++; $display("FAIL ovf_status got=%h exp=%h", r, 32'h2); end
        send("K"); send(8'd13);
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h103 || r !== m_status()) begin bad++; $display("FAIL ovf_recover_status got=%h exp=%h", r, 32'h103); end
        bus(A_DT, 0, 0, r); e = m_pop();
        total++; if (r !== 32'h14B || r !== e) begin bad++; $display("FAIL ovf_recover_pop got=%h exp=%h", r, 32'h14B); end
        bus(A_DT, 0, 0, r); e = m_pop();
        total++; if (r !== e) begin bad++; $display("FAIL ovf_recover_cr got=%h exp=%h", r, e); end
        bus(A_CT, 32'h1, 4'hF, r); m_ovf = 0; m_edrop = 0;
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL ovf_clear got=%h exp=0", r); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] r, e;
        send(8'd13); send(8'd13); send("B");
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h201) begin bad++; $display("FAIL simul_pre got=%h exp=%h", r, 32'h201); end
        do_simul(8'd13, r, e);
        total++; if (r !== 32'h10D || r !== e) begin bad++; $display("FAIL simul_pop got=%h exp=%h", r, 32'h10D); end
        bus(A_ST, 0, 0, r);
        total++; if (r !== 32'h201 || r !== m_status()) begin bad++; $display("FAIL simul_count got=%h exp=%h", r, 32'h201); end
        for (int i = 0; i < 4; i++) begin
            bus(A_DT, 0, 0, r); e = m_pop();
            total++; if (r !== e) begin bad++; $display("FAIL simul_drain%0d got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_reset_midline();
        logic [31:0] r, e;
        send("1"); send("2"); send("3");
        do_reset();
        send("Z"); send(8'd13);
        for (int i = 0; i < 3; i++) begin
            bus(A_DT, 0, 0, r); e = m_pop();
            total++; if (r !== e) begin bad++; $display("FAIL midreset_pop%0d got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] r, e;
        send("C"); send(8'd13); send("D");
        @(posedge clk); #1 valid = 1; address = A_CT; wdata = 32'h2; wstrb = 4'hF; rx_data = "E"; rx_valid = 1;
        @(posedge clk); #1 rx_valid = 0; valid = 0; wstrb = 0; wdata = 0;
        total++; if (ready !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL flush_ack ready=%b rdata=%h required 1/0", ready, rdata); end
        m_com.delete(); m_pend.delete(); m_disc = 0;
        bus(A_ST, 0, 0, r);
        total++; if (r !== m_status() || r[15:0] !== 16'h0 && r[15:0] !== 16'h4) begin bad++; $display("FAIL flush_status got=%h exp=%h", r, m_status()); end
        send("F"); send(8'd13);
        for (int i = 0; i < 3; i++) begin
            bus(A_DT, 0, 0, r); e = m_pop();
            total++; if (r !== e) begin bad++; $display("FAIL flush_after%0d got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_misc_regs();
        logic [31:0] r, e;
        send("M"); send(8'd13);
        bus(A_ST, 32'h3, 4'hF, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL wr_status got=%h exp=0", r); end
        bus(A_DT, 32'h0, 4'hF, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL wr_data got=%h exp=0", r); end
        bus(A_CT, 0, 0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rd_ctrl got=%h exp=0", r); end
        bus(2'd3, 32'h3, 4'hF, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL wr_addr3 got=%h exp=0", r); end
        bus(2'd3, 0, 0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rd_addr3 got=%h exp=0", r); end
        bus(A_ST, 0, 0, r);
        total++; if (r !== m_status()) begin bad++; $display("FAIL misc_status got=%h exp=%h", r, m_status()); end
        for (int i = 0; i < 2; i++) begin
            bus(A_DT, 0, 0, r); e = m_pop();
            total++; if (r !== e) begin bad++; $display("FAIL misc_pop%0d got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1 valid = 1; address = A_ST; wstrb = 0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_first ready=%b required=1", ready); end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_gap ready=%b required=0", ready); end
        @(posedge clk); #1;
        total++; if (ready !== 1'b1 || rdata !== m_status()) begin bad++; $display("FAIL b2b_second ready=%b rdata=%h required 1/%h", ready, rdata, m_status()); end
        valid = 0;
    endtask

    task automatic test_random();
        logic [31:0] r, e;
        logic [7:0] b;
        int k;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            b = ($urandom_range(0, 3) == 0) ? 8'd13 : 8'(65 + $urandom_range(0, 25));
            if (k < 4) send(b);
            else if (k < 7) begin
                bus(A_DT, 0, 0, r); e = m_pop();
                total++; if (r !== e) begin bad++; $display("FAIL rand_pop n=%0d got=%h exp=%h", n, r, e); end
            end else if (k < 8) begin
                bus(A_ST, 0, 0, r);
                total++; if (r !== m_status()) begin bad++; $display("FAIL rand_status n=%0d got=%h exp=%h", n, r, m_status()); end
            end else if (k < 9) begin
                do_simul(b, r, e);
                total++; if (r !== e) begin bad++; $display("FAIL rand_simul n=%0d got=%h exp=%h", n, r, e); end
            end else begin
                bus(A_CT, 32'h1, 4'hF, r); m_ovf = 0; m_edrop = 0;
                total++; if (r !== 32'h0) begin bad++; $display("FAIL rand_clr n=%0d got=%h exp=0", n, r); end
            end
        end
    endtask

    task automatic test_echo();
        logic [31:0] r;
        do_reset();
        tx_ready = 0;
`ifdef UART_LINE_BUFFER_ECHO_EN
        send("a"); send("b");
        total++; if (tx_valid !== 1'b1 || tx_data !== m_tx_data) begin bad++; $display("FAIL echo_hold tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, m_tx_data); end
        bus(A_ST, 0, 0, r);
        total++; if (r[2] !== 1'b1 || r !== m_status()) begin bad++; $display("FAIL echo_drop got=%h exp=%h", r, m_status()); end
        @(posedge clk); #1 tx_ready = 1;
        @(posedge clk); #1;
        m_tx_occ = 0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL echo_release tx_valid=%b required=0", tx_valid); end
        tx_ready = 0;
        bus(A_CT, 32'h1, 4'hF, r); m_ovf = 0; m_edrop = 0;
        bus(A_ST, 0, 0, r);
        total++; if (r !== m_status()) begin bad++; $display("FAIL echo_clear got=%h exp=%h", r, m_status()); end
`else
        tx_ready = 1;
        send("a"); send("b");
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin bad++; $display("FAIL echo_off tx_valid=%b tx_data=%h required 0/0", tx_valid, tx_data); end
        bus(A_ST, 0, 0, r);
        total++; if (r[2] !== 1'b0 || r !== m_status()) begin bad++; $display("FAIL echo_off_status got=%h exp=%h", r, m_status()); end
        tx_ready = 0;
`endif
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic_line();
        test_uncommitted();
        test_overflow();
        test_simultaneous();
        test_reset_midline();
        test_flush();
        test_misc_regs();
        test_back_to_back();
        do_reset();
        test_random();
        test_echo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
